fb_painter24: RTL and testbench
===============================

FB_PAINTER24 -- requirements
Module: fb_painter24

Interface
REQ-001 FRAME_BITS, default 10, width of frame input.
REQ-002 HALF, default 0, panel half served; instance stores only rows with y[5]==HALF.
REQ-003 clk  input  1  pixel clock (PLL clock domain).
REQ-004 resetn  input  1  one clock; reset is asynchronous and active-low.
REQ-005 frame  input  FRAME_BITS  display frame counter from the scan pipeline.
REQ-006 subframe  input  8  PWM subframe index; unused, accepted for port compatibility.
REQ-007 x  input  6  display column.
REQ-008 y  input  6  display row.
REQ-009 rgb24  output  24  display pixel; [7:0] R, [15:8] G, [23:16] B.
REQ-010 wr_valid  input  1  write request from host loader.
REQ-011 wr_ready  output  1  write accepted when wr_valid && wr_ready on a rising clk edge.
REQ-012 wr_x  input  6  write column.
REQ-013 wr_y  input  6  write row.
REQ-014 wr_rgb  input  12  RGB444 pixel; [3:0] R, [7:4] G, [11:8] B.
REQ-015 wr_last  input  1  qualifies accepted write as last of host frame; requests buffer swap.
REQ-016 swap_pending  output  1  high from wr_last acceptance until swap completes.

Function
REQ-017 Storage: two banks, each 32 rows x 64 columns x 12 bits, address {y[4:0], x}; one display bank, one write bank.
REQ-018 Display read: rgb24 registered, latency exactly 1 clk from x/y to rgb24; reads the display bank only.
REQ-019 Expansion: each 4-bit channel n emitted as 8-bit {n,n}; 0x0->0x00, 0xF->0xFF.
REQ-020 Display read ignores y[5]; the instance returns row y[4:0] of its own half.
REQ-021 Accepted write with wr_y[5]==HALF stores wr_rgb into write bank at {wr_y[4:0], wr_x}; wr_y[5]!=HALF is accepted and discarded (handshake still completes).
REQ-022 FSM states: S_CLEAR, S_IDLE, S_PENDING.
REQ-023 S_CLEAR: zero one address of both banks per clk, 2048 clks, addresses 0..2047 ascending; wr_ready=0; rgb24 forced 0; then S_IDLE.
REQ-024 S_IDLE: wr_ready=1; accepted write with wr_last=1 stores its pixel (per REQ-021), sets swap_pending, goes to S_PENDING.
REQ-025 S_PENDING: wr_ready=0; on first clk where frame != frame_q, display/write banks exchange, swap_pending clears, go to S_IDLE.
REQ-026 frame_q: register updated with frame every clk in S_IDLE and S_PENDING; held at 0 in S_CLEAR.
REQ-027 Frame change in the same clk as wr_last acceptance does not swap; swap waits for the next frame change.
REQ-028 Swap takes effect for reads issued the clk after the swap edge; no torn read within a single clk.
REQ-029 frame wrap-around (all ones -> 0) counts as a frame change.
REQ-030 Write bank not cleared on swap; host overwrites every pixel it needs.
REQ-031 x/y and wr_x/wr_y addressing never conflicts: reads and writes always target different banks.

Reset
REQ-032 resetn low asynchronously forces: FSM S_CLEAR with clear address 0, display bank 0, write bank 1, swap_pending 0, wr_ready 0, rgb24 0, frame_q 0.
REQ-033 resetn asserted mid-clear, mid-write or in S_PENDING aborts the operation; pending swap discarded; clear restarts from address 0 after release.
REQ-034 RAM arrays themselves are not reset; S_CLEAR provides defined contents.

Verification
REQ-035 Release reset -> wr_ready 0 for exactly 2048 clks, then 1; rgb24 == 0 for every x,y read afterwards.
REQ-036 HALF=0: write (x=5,y=3,0xA5F), wr_last, then frame 0->1 -> swap_pending falls one clk after change; read x=5,y=3 gives rgb24 0xAA55FF one clk later.
REQ-037 HALF=0: write (x=5,y=35,0x123) plus wr_last, swap -> handshake completes, read x=5,y=3 returns 0x000000.
REQ-038 wr_last accepted on same clk frame changes 4->5 -> no swap; swap occurs at 5->6; wr_ready 0 throughout.
REQ-039 frame 0x3FF->0x000 while pending -> swap occurs.
REQ-040 Assert resetn low while swap_pending=1 -> after release, display bank 0, swap_pending 0, clear re-runs 2048 clks.

Source files
------------

// File: rtl/fb_painter24.sv
// Double-buffered 64x32 RGB444 frame store for one half of a 64x64 panel.
// The host fills the write bank; the banks exchange on the next display frame change.
module fb_painter24 #(
   parameter int FRAME_BITS = 10,
   parameter int HALF       = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [FRAME_BITS-1:0] frame,
   input  logic [7:0]            subframe,
   input  logic [5:0]            x,
   input  logic [5:0]            y,
   output logic [23:0]           rgb24,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [5:0]            wr_x,
   input  logic [5:0]            wr_y,
   input  logic [11:0]           wr_rgb,
   input  logic                  wr_last,
   output logic                  swap_pending
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_PENDING
   } state_t;

   localparam logic HALF_BIT = HALF[0];

   state_t                state_q, state_d;
   logic [10:0]           clr_addr_q, clr_addr_d;
   logic                  disp_bank_q, disp_bank_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [23:0]           rgb24_q, rgb24_d;

   logic [11:0] mem0 [2048];
   logic [11:0] mem1 [2048];

   logic        we0, we1;
   logic [10:0] waddr;
   logic [11:0] wdata;
   logic [10:0] raddr;
   logic [11:0] rd_pix;

   // Subframe and the row's half bit do not affect the stored image.
   logic unused_inputs;
   assign unused_inputs = ^{subframe, y[5]};

   assign wr_ready     = (state_q == S_IDLE);
   assign swap_pending = (state_q == S_PENDING);
   assign rgb24        = rgb24_q;

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      disp_bank_d = disp_bank_q;
      frame_d     = frame;
      we0         = 1'b0;
      we1         = 1'b0;
      waddr       = {wr_y[4:0], wr_x};
      wdata       = wr_rgb;

      case (state_q)
         S_CLEAR: begin
            frame_d    = '0;
            we0        = 1'b1;
            we1        = 1'b1;
            waddr      = clr_addr_q;
            wdata      = '0;
            clr_addr_d = clr_addr_q + 11'd1;
            if (clr_addr_q == 11'h7FF) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (wr_valid) begin
               // Rows belonging to the other half complete the handshake but are dropped.
               if (wr_y[5] == HALF_BIT) begin
                  we0 = disp_bank_q;
                  we1 = ~disp_bank_q;
               end
               if (wr_last) begin
                  state_d = S_PENDING;
               end
            end
         end
         S_PENDING: begin
            if (frame != frame_q) begin
               disp_bank_d = ~disp_bank_q;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   assign raddr  = {y[4:0], x};
   assign rd_pix = disp_bank_q ? mem1[raddr] : mem0[raddr];

   always_comb begin
      rgb24_d = {rd_pix[11:8], rd_pix[11:8],
                 rd_pix[7:4],  rd_pix[7:4],
                 rd_pix[3:0],  rd_pix[3:0]};
      if (state_q == S_CLEAR) begin
         rgb24_d = '0;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_CLEAR;
         clr_addr_q  <= '0;
         disp_bank_q <= 1'b0;
         frame_q     <= '0;
         rgb24_q     <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         disp_bank_q <= disp_bank_d;
         frame_q     <= frame_d;
         rgb24_q     <= rgb24_d;
      end
   end

   // NOTE: the arrays carry no reset so they map onto RAM; the clear state
   // gives them defined contents instead.
   always_ff @(posedge clk) begin
      if (we0) begin
         mem0[waddr] <= wdata;
      end
      if (we1) begin
         mem1[waddr] <= wdata;
      end
   end

endmodule

// File: tb/tb_fb_painter24.sv
// Directed bench for fb_painter24 (HALF=0): clear length, writes, swaps, frame edge cases, reset abort.
module tb_fb_painter24;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [9:0]  frame = '0;
   logic [7:0]  subframe = '0;
   logic [5:0]  x = '0;
   logic [5:0]  y = '0;
   logic [23:0] rgb24;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [5:0]  wr_x = '0;
   logic [5:0]  wr_y = '0;
   logic [11:0] wr_rgb = '0;
   logic        wr_last = 1'b0;
   logic        swap_pending;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fb_painter24 #(.FRAME_BITS(10), .HALF(0)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .frame        (frame),
      .subframe     (subframe),
      .x            (x),
      .y            (y),
      .rgb24        (rgb24),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_rgb       (wr_rgb),
      .wr_last      (wr_last),
      .swap_pending (swap_pending)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts clocks until wr_ready rises; optionally probes the forced-zero output mid-clear.
   task automatic run_clear(input string tag, input bit probe);
      int n = 0;
      while (!wr_ready && n < 3000) begin
         tick();
         n++;
         if (probe && n == 12) check({tag, "_forced_zero"}, 32'(rgb24), 32'h0);
      end
      check({tag, "_clear_len"}, 32'(n), 32'd2048);
   endtask

   task automatic write_px(input logic [5:0] px, input logic [5:0] py,
                           input logic [11:0] pix, input logic last);
      wr_x     = px;
      wr_y     = py;
      wr_rgb   = pix;
      wr_last  = last;
      wr_valid = 1'b1;
      check("wr_ready_at_write", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic read_px(input string tag, input logic [5:0] px, input logic [5:0] py,
                          input logic [23:0] exp);
      x = px;
      y = py;
      tick();
      check(tag, 32'(rgb24), 32'(exp));
   endtask

   task automatic frame_step(input string tag, input logic [9:0] f);
      frame = f;
      check({tag, "_pending_before"}, 32'(swap_pending), 32'd1);
      tick();
      check({tag, "_pending_after"}, 32'(swap_pending), 32'd0);
   endtask

   initial begin
      #1 resetn = 1'b0;
      #11;
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_pending", 32'(swap_pending), 32'd0);
      check("rst_rgb24", 32'(rgb24), 32'h0);
      resetn = 1'b1;
      run_clear("init", 1'b0);

      read_px("clr_0_0", 6'd0, 6'd0, 24'h0);
      read_px("clr_63_63", 6'd63, 6'd63, 24'h0);
      read_px("clr_5_3", 6'd5, 6'd3, 24'h0);

      // Basic write and swap.
      write_px(6'd5, 6'd3, 12'hA5F, 1'b1);
      check("p1_pending", 32'(swap_pending), 32'd1);
      check("p1_wr_ready", 32'(wr_ready), 32'd0);
      repeat (3) tick();
      check("p1_hold", 32'(swap_pending), 32'd1);
      read_px("p1_old_bank", 6'd5, 6'd3, 24'h0);
      frame_step("swap1", 10'd1);
      read_px("p1_new_bank", 6'd5, 6'd3, 24'hAA55FF);
      read_px("p1_y5_ignored", 6'd5, 6'd35, 24'hAA55FF);
      read_px("p1_neighbour", 6'd6, 6'd3, 24'h0);

      // Write to the other half is discarded.
      write_px(6'd5, 6'd35, 12'h123, 1'b1);
      check("p2_pending", 32'(swap_pending), 32'd1);
      frame_step("swap2", 10'd2);
      read_px("p2_5_3", 6'd5, 6'd3, 24'h0);
      read_px("p2_5_35", 6'd5, 6'd35, 24'h0);

      // Several pixels, only the last one requests the swap; old content persists.
      write_px(6'd0, 6'd0, 12'hFFF, 1'b0);
      check("p3_no_pending", 32'(swap_pending), 32'd0);
      write_px(6'd63, 6'd31, 12'h08F, 1'b0);
      write_px(6'd2, 6'd2, 12'h3C7, 1'b1);
      frame_step("swap3", 10'd3);
      read_px("p3_0_0", 6'd0, 6'd0, 24'hFFFFFF);
      read_px("p3_63_31", 6'd63, 6'd31, 24'h0088FF);
      read_px("p3_2_2", 6'd2, 6'd2, 24'h33CC77);
      read_px("p3_persist", 6'd5, 6'd3, 24'hAA55FF);

      // Frame change coinciding with wr_last acceptance does not swap.
      frame = 10'd4;
      repeat (2) tick();
      wr_x     = 6'd10;
      wr_y     = 6'd10;
      wr_rgb   = 12'h5A0;
      wr_last  = 1'b1;
      wr_valid = 1'b1;
      frame    = 10'd5;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      check("p4_pending", 32'(swap_pending), 32'd1);
      repeat (5) begin
         tick();
         check("p4_still_pending", 32'(swap_pending), 32'd1);
         check("p4_wr_ready_low", 32'(wr_ready), 32'd0);
      end
      frame_step("swap4", 10'd6);
      read_px("p4_10_10", 6'd10, 6'd10, 24'h55AA00);

      // Frame counter wrap counts as a change.
      frame = 10'h3FF;
      repeat (2) tick();
      write_px(6'd1, 6'd2, 12'h111, 1'b1);
      frame_step("swap_wrap", 10'h000);
      read_px("p5_1_2", 6'd1, 6'd2, 24'h111111);

      // Reset while a swap is pending.
      write_px(6'd20, 6'd20, 12'hF00, 1'b1);
      check("p6_pending", 32'(swap_pending), 32'd1);
      x = 6'd10;
      y = 6'd10;
      #2 resetn = 1'b0;
      #1;
      check("p6_rst_pending", 32'(swap_pending), 32'd0);
      check("p6_rst_wr_ready", 32'(wr_ready), 32'd0);
      check("p6_rst_rgb24", 32'(rgb24), 32'h0);
      tick();
      resetn = 1'b1;
      run_clear("rerun", 1'b1);
      check("p6_pending_idle", 32'(swap_pending), 32'd0);
      read_px("p6_10_10", 6'd10, 6'd10, 24'h0);
      read_px("p6_1_2", 6'd1, 6'd2, 24'h0);
      write_px(6'd7, 6'd7, 12'hABC, 1'b1);
      frame_step("swap_after_rst", 10'd1);
      read_px("p6_7_7", 6'd7, 6'd7, 24'hAABBCC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
